ldlt_solve: RTL and testbench
=============================

// Module: ldlt_solve
// PURPOSE
//  Back-end of the 6x6 LDL^T solver path: consumes unit-lower L and diagonal D from the factorisation block
//  and solves L*D*L^T*x = b for the 6x1 Gauss-Newton update of the RGB-D VO pose estimator.
//  Forward substitution (z = L^-1*b), diagonal scaling (y = z/D), back substitution (x = L^-T*y).
//  Uses one time-shared multiplier and one pipelined divider; fixed latency; signed fixed point throughout.
// PARAMETERS
//  BW       42  total signed width of every L, D, b, x word (two's complement)
//  FRAC     24  fractional bits (1.0 = 2^FRAC)
//  DIV_LAT  3   divider pipeline latency in cycles (>=1)
// PORTS
//  i_clk              in   1    clock, all logic on rising edge
//  i_rst_n            in   1    synchronous active-low reset
//  i_start            in   1    start pulse; sampled only in IDLE
//  i_L_10..i_L_54     in   BW   15 strictly-lower L entries i_L_rc (r>c); unit diagonal implied, not ported
//  i_D_0..i_D_5       in   BW   diagonal D entries
//  i_b_0..i_b_5       in   BW   right-hand side vector
//  o_busy             out  1    high from cycle after start accept until o_done cycle inclusive
//  o_done             out  1    one-cycle pulse, o_x_* valid from this cycle on
//  o_div_zero         out  1    valid with o_done: 1 if any D_i == 0 in this solve
//  o_x_0..o_x_5       out  BW   solution vector
// BEHAVIOUR
//  Reset (i_rst_n low at posedge): state IDLE; o_busy, o_done, o_div_zero = 0; o_x_* = 0; internal regs = 0.
//  Reset mid-solve aborts immediately; no o_done; next i_start after release starts a clean solve.
//  FSM: IDLE -> FWD -> DIAG -> BWD -> DONE -> IDLE.
//   IDLE: i_start=1 latches all L, D, b into internal regs (cycle 0); go FWD. Inputs ignored afterwards.
//   FWD : 15 cycles, one MAC/cycle, order i=1..5, k=0..i-1: z_i <= z_i - rnd(L_ik*z_k); z starts as b.
//   DIAG: 6 issue cycles (i=0..5, a={z_i,FRAC'b0}, b=D_i) + DIV_LAT drain; y_i written on return.
//   BWD : 15 cycles, order i=4..0, k=5..i+1 descending: x_i <= x_i - rnd(L_ki*x_k); x starts as y.
//   DONE: 1 cycle; o_done=1, o_x_* and o_div_zero loaded; return to IDLE next cycle.
//  Latency: o_done asserted exactly 37+DIV_LAT cycles after the accepting cycle (40 at default).
//  i_start while not IDLE (incl. DONE cycle) ignored; back-to-back: start accepted the cycle after DONE.
//  o_x_* / o_div_zero change only in DONE cycle; held otherwise (also during next solve).
//  Product rounding rnd(p): 2*BW-bit signed product, shifted right FRAC with truncation toward zero
//   (negative p: add 2^FRAC-1 before arithmetic shift), then truncated to BW bits.
//  Division: signed (BW+FRAC)/BW, quotient truncated toward zero, low BW bits kept.
//  D_i == 0: quotient forced to 0 (y_i = 0), sticky div_zero flag set; solve still completes on schedule.
//  Subtractions wrap modulo 2^BW; no saturation; no overflow flag.
// TESTING
//  T1 identity: all L=0, D_i=2.0 (33554432), b_i=4.0 (67108864) -> o_x_i=2.0 (33554432), div_zero=0, done at +40.
//  T2 coupling: L_10=0.5 (8388608), other L=0, all D=1.0, b_0=b_1=1.0 -> x_0=0.75 (12582912), x_1=0.5 (8388608),
//     x_2..x_5=1.0 (16777216).
//  T3 rounding: L_10=-1.0, D=1.0, b_0=-1 LSB, b_1=0 -> z_1=-1 LSB exact; L_10=0.5, b_0=-1 LSB -> rnd(-0.5 LSB)=0, z_1=b_1.
//  T4 div-zero: D_3=0, others 1.0, L=0, b_i=1.0 -> x_3=0, other x_i=1.0, o_div_zero=1 with o_done.
//  T5 control: i_start pulsed again at cycles 5 and 40 -> ignored, single o_done at 40;
//     start at cycle 41 accepted, o_done at 81 with new result, o_x_* held 40..80.
//  T6 reset: i_rst_n low at cycle 20 for 1 cycle -> all outputs 0, no o_done; fresh T1 then passes with done at +40.

Source files
------------

// File: rtl/ldlt_solve.sv
// Back-end of the 6x6 LDL^T solver: forward substitution, diagonal scaling and back
// substitution on a single time-shared multiplier and a pipelined divider, fixed latency.
module ldlt_solve #(
    parameter int BW      = 42,
    parameter int FRAC    = 24,
    parameter int DIV_LAT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic signed [BW-1:0] i_L_10,
    input  logic signed [BW-1:0] i_L_20,
    input  logic signed [BW-1:0] i_L_21,
    input  logic signed [BW-1:0] i_L_30,
    input  logic signed [BW-1:0] i_L_31,
    input  logic signed [BW-1:0] i_L_32,
    input  logic signed [BW-1:0] i_L_40,
    input  logic signed [BW-1:0] i_L_41,
    input  logic signed [BW-1:0] i_L_42,
    input  logic signed [BW-1:0] i_L_43,
    input  logic signed [BW-1:0] i_L_50,
    input  logic signed [BW-1:0] i_L_51,
    input  logic signed [BW-1:0] i_L_52,
    input  logic signed [BW-1:0] i_L_53,
    input  logic signed [BW-1:0] i_L_54,
    input  logic signed [BW-1:0] i_D_0,
    input  logic signed [BW-1:0] i_D_1,
    input  logic signed [BW-1:0] i_D_2,
    input  logic signed [BW-1:0] i_D_3,
    input  logic signed [BW-1:0] i_D_4,
    input  logic signed [BW-1:0] i_D_5,
    input  logic signed [BW-1:0] i_b_0,
    input  logic signed [BW-1:0] i_b_1,
    input  logic signed [BW-1:0] i_b_2,
    input  logic signed [BW-1:0] i_b_3,
    input  logic signed [BW-1:0] i_b_4,
    input  logic signed [BW-1:0] i_b_5,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_div_zero,
    output logic signed [BW-1:0] o_x_0,
    output logic signed [BW-1:0] o_x_1,
    output logic signed [BW-1:0] o_x_2,
    output logic signed [BW-1:0] o_x_3,
    output logic signed [BW-1:0] o_x_4,
    output logic signed [BW-1:0] o_x_5
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_DIAG = 3'd2;
    localparam logic [2:0] S_BWD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int QW        = BW + FRAC;
    localparam int DIAG_LAST = 5 + DIV_LAT;
    localparam logic signed [2*BW-1:0] RND_BIAS = (2*BW)'((64'd1 << FRAC) - 64'd1);

    logic [2:0]           state;
    logic signed [BW-1:0] lmat [6][6];
    logic signed [BW-1:0] dvec [6];
    logic signed [BW-1:0] w    [6];    // holds z, then y, then x in place
    logic signed [BW-1:0] x_out [6];
    logic [2:0]           ri;
    logic [2:0]           ci;
    logic [7:0]           cnt;
    logic                 div_zero;
    logic                 dz_out;

    logic signed [BW-1:0] pipe_q   [DIV_LAT];
    logic [2:0]           pipe_idx [DIV_LAT];
    logic [DIV_LAT-1:0]   pipe_vld;

    logic signed [BW-1:0]   l_op;
    logic signed [2*BW-1:0] prod;
    logic signed [2*BW-1:0] prod_adj;
    logic signed [BW-1:0]   mac_res;
    logic [2:0]             d_idx;
    logic                   issue;
    logic                   d_zero;
    logic signed [QW-1:0]   num;
    logic signed [QW-1:0]   den;
    logic signed [BW-1:0]   quot;

    // NOTE: every combinational output is given a value on every path, so no latch is inferred.
    always_comb begin
        l_op     = (state == S_BWD) ? lmat[ci][ri] : lmat[ri][ci];
        prod     = (2*BW)'(l_op) * (2*BW)'(w[ci]);
        prod_adj = prod + (prod[2*BW-1] ? RND_BIAS : '0);
        mac_res  = w[ri] - BW'(prod_adj >>> FRAC);

        d_idx  = cnt[2:0];
        issue  = (state == S_DIAG) && (cnt < 8'd6);
        d_zero = (dvec[d_idx] == '0);
        num    = {w[d_idx], {FRAC{1'b0}}};
        den    = d_zero ? QW'(1) : QW'(dvec[d_idx]);
        quot   = d_zero ? '0 : BW'(num / den);
    end

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: operand arrays are cleared too, so an aborted solve leaves nothing stale behind.
            state    <= S_IDLE;
            ri       <= '0;
            ci       <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            dz_out   <= 1'b0;
            pipe_vld <= '0;
            for (int r = 0; r < 6; r++) begin
                dvec[r]  <= '0;
                w[r]     <= '0;
                x_out[r] <= '0;
                for (int c = 0; c < 6; c++) lmat[r][c] <= '0;
            end
            for (int j = 0; j < DIV_LAT; j++) begin
                pipe_q[j]   <= '0;
                pipe_idx[j] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    lmat[1][0] <= i_L_10;
                    lmat[2][0] <= i_L_20; lmat[2][1] <= i_L_21;
                    lmat[3][0] <= i_L_30; lmat[3][1] <= i_L_31; lmat[3][2] <= i_L_32;
                    lmat[4][0] <= i_L_40; lmat[4][1] <= i_L_41; lmat[4][2] <= i_L_42;
                    lmat[4][3] <= i_L_43;
                    lmat[5][0] <= i_L_50; lmat[5][1] <= i_L_51; lmat[5][2] <= i_L_52;
                    lmat[5][3] <= i_L_53; lmat[5][4] <= i_L_54;
                    dvec[0] <= i_D_0; dvec[1] <= i_D_1; dvec[2] <= i_D_2;
                    dvec[3] <= i_D_3; dvec[4] <= i_D_4; dvec[5] <= i_D_5;
                    w[0] <= i_b_0; w[1] <= i_b_1; w[2] <= i_b_2;
                    w[3] <= i_b_3; w[4] <= i_b_4; w[5] <= i_b_5;
                    ri       <= 3'd1;
                    ci       <= 3'd0;
                    div_zero <= 1'b0;
                    state    <= S_FWD;
                end
                S_FWD: begin
                    w[ri] <= mac_res;
                    if (ri == 3'd5 && ci == 3'd4) begin
                        cnt   <= '0;
                        state <= S_DIAG;
                    end else if (ci == ri - 3'd1) begin
                        ri <= ri + 3'd1;
                        ci <= 3'd0;
                    end else begin
                        ci <= ci + 3'd1;
                    end
                end
                S_DIAG: begin
                    if (issue && d_zero) div_zero <= 1'b1;
                    cnt <= cnt + 8'd1;
                    if (cnt == DIAG_LAST[7:0]) begin
                        ri    <= 3'd4;
                        ci    <= 3'd5;
                        state <= S_BWD;
                    end
                end
                S_BWD: begin
                    w[ri] <= mac_res;
                    if (ri == 3'd0 && ci == 3'd1) begin
                        // the final MAC result is forwarded so o_x_* is complete in the DONE cycle
                        for (int j = 0; j < 6; j++) x_out[j] <= (ri == 3'(j)) ? mac_res : w[j];
                        dz_out <= div_zero;
                        state  <= S_DONE;
                    end else if (ci == ri + 3'd1) begin
                        ri <= ri - 3'd1;
                        ci <= 3'd5;
                    end else begin
                        ci <= ci - 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            pipe_vld[0] <= issue;
            pipe_q[0]   <= quot;
            pipe_idx[0] <= d_idx;
            for (int j = 1; j < DIV_LAT; j++) begin
                pipe_vld[j] <= pipe_vld[j-1];
                pipe_q[j]   <= pipe_q[j-1];
                pipe_idx[j] <= pipe_idx[j-1];
            end
            if (pipe_vld[DIV_LAT-1]) w[pipe_idx[DIV_LAT-1]] <= pipe_q[DIV_LAT-1];
        end
    end

    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);
    assign o_div_zero = dz_out;
    assign o_x_0      = x_out[0];
    assign o_x_1      = x_out[1];
    assign o_x_2      = x_out[2];
    assign o_x_3      = x_out[3];
    assign o_x_4      = x_out[4];
    assign o_x_5      = x_out[5];

endmodule

// File: tb/tb_ldlt_solve.sv
// Directed testbench for ldlt_solve: hand-computed solutions, latency, control and reset behaviour.
module tb_ldlt_solve;

    localparam int BW = 42;
    localparam logic signed [BW-1:0] ONE = 42'sd16777216;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 start;
    logic signed [BW-1:0] l_in [6][6];
    logic signed [BW-1:0] d_in [6];
    logic signed [BW-1:0] b_in [6];
    logic                 busy;
    logic                 done;
    logic                 div_zero;
    logic signed [BW-1:0] x0, x1, x2, x3, x4, x5;
    logic signed [BW-1:0] x_arr [6];
    logic signed [BW-1:0] exp_x [6];
    logic signed [BW-1:0] exp_t1 [6];
    logic signed [BW-1:0] exp_t2 [6];

    int n_cmp = 0;
    int n_err = 0;

    assign x_arr[0] = x0;
    assign x_arr[1] = x1;
    assign x_arr[2] = x2;
    assign x_arr[3] = x3;
    assign x_arr[4] = x4;
    assign x_arr[5] = x5;

    ldlt_solve dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_L_10(l_in[1][0]),
        .i_L_20(l_in[2][0]), .i_L_21(l_in[2][1]),
        .i_L_30(l_in[3][0]), .i_L_31(l_in[3][1]), .i_L_32(l_in[3][2]),
        .i_L_40(l_in[4][0]), .i_L_41(l_in[4][1]), .i_L_42(l_in[4][2]), .i_L_43(l_in[4][3]),
        .i_L_50(l_in[5][0]), .i_L_51(l_in[5][1]), .i_L_52(l_in[5][2]), .i_L_53(l_in[5][3]),
        .i_L_54(l_in[5][4]),
        .i_D_0(d_in[0]), .i_D_1(d_in[1]), .i_D_2(d_in[2]),
        .i_D_3(d_in[3]), .i_D_4(d_in[4]), .i_D_5(d_in[5]),
        .i_b_0(b_in[0]), .i_b_1(b_in[1]), .i_b_2(b_in[2]),
        .i_b_3(b_in[3]), .i_b_4(b_in[4]), .i_b_5(b_in[5]),
        .o_busy(busy), .o_done(done), .o_div_zero(div_zero),
        .o_x_0(x0), .o_x_1(x1), .o_x_2(x2), .o_x_3(x3), .o_x_4(x4), .o_x_5(x5)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // All L cleared, every D and b set to one value.
    task automatic fill(input logic signed [BW-1:0] dv, input logic signed [BW-1:0] bv);
        for (int r = 0; r < 6; r++) begin
            d_in[r] = dv;
            b_in[r] = bv;
            for (int c = 0; c < 6; c++) l_in[r][c] = '0;
        end
    endtask

    task automatic check_x(input string tag, input logic signed [BW-1:0] e [6]);
        for (int i = 0; i < 6; i++) check($sformatf("%s x_%0d", tag, i), x_arr[i], e[i]);
    endtask

    // Pulse start from the current negedge, wait (bounded) for o_done, check latency and results.
    task automatic run_solve(input string tag, input logic signed [BW-1:0] e [6],
                             input logic exp_dz);
        int cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, 40);
        check({tag, " busy@done"}, busy, 1);
        check_x(tag, e);
        check({tag, " div_zero"}, div_zero, exp_dz);
        @(negedge clk);
        check({tag, " done pulse"}, done, 0);
        check({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        int  ndone;
        int  hold_err;
        bit  saw40;
        bit  saw81;

        rst_n = 1'b0;
        start = 1'b0;
        fill('0, '0);
        for (int i = 0; i < 6; i++) begin
            exp_t1[i] = 42'sd33554432;
            exp_t2[i] = ONE;
        end
        exp_t2[0] = 42'sd12582912;
        exp_t2[1] = 42'sd8388608;

        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);
        check("reset x_0", x0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1 identity
        fill(2 * ONE, 4 * ONE);
        run_solve("T1", exp_t1, 1'b0);

        // T2 coupling through L_10 = 0.5
        fill(ONE, ONE);
        l_in[1][0] = ONE / 2;
        run_solve("T2", exp_t2, 1'b0);

        // T3a: L_10 = -1.0, b_0 = -1 LSB -> exact product, z_1 = -1, x_0 = -2
        fill(ONE, '0);
        l_in[1][0] = -ONE;
        b_in[0]    = -42'sd1;
        for (int i = 0; i < 6; i++) exp_x[i] = '0;
        exp_x[0] = -42'sd2;
        exp_x[1] = -42'sd1;
        run_solve("T3a", exp_x, 1'b0);

        // T3b: rnd(-0.5 LSB) truncates toward zero, so z_1 stays 0
        l_in[1][0] = ONE / 2;
        exp_x[0] = -42'sd1;
        exp_x[1] = '0;
        run_solve("T3b", exp_x, 1'b0);

        // T4: D_3 = 0 forces y_3 = 0 and raises div_zero
        fill(ONE, ONE);
        d_in[3] = '0;
        for (int i = 0; i < 6; i++) exp_x[i] = ONE;
        exp_x[3] = '0;
        run_solve("T4", exp_x, 1'b1);

        // T5: extra starts ignored while busy/DONE, back-to-back start right after DONE
        fill(ONE, ONE);
        l_in[1][0] = ONE / 2;
        ndone = 0; hold_err = 0; saw40 = 1'b0; saw81 = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (c == 40) saw40 = 1'b1;
                if (c == 81) saw81 = 1'b1;
            end
            if (c == 1)  check("T5 busy c1", busy, 1);
            if (c == 40) check_x("T5 first", exp_t2);
            if (c == 41) check("T5 busy c41", busy, 0);
            if (c >= 41 && c <= 80)
                for (int i = 0; i < 6; i++) if (x_arr[i] !== exp_t2[i]) hold_err++;
            if (c == 81) check_x("T5 second", exp_t1);
            start = (c == 5 || c == 40 || c == 41);
            if (c == 10) fill(2 * ONE, 4 * ONE);
        end
        start = 1'b0;
        check("T5 done count", ndone, 2);
        check("T5 done@40", saw40, 1);
        check("T5 done@81", saw81, 1);
        check("T5 hold errors", hold_err, 0);

        // T6: reset mid-solve aborts with no o_done, then a clean solve
        fill(2 * ONE, 4 * ONE);
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("T6 busy", busy, 0);
        check("T6 done", done, 0);
        check("T6 div_zero", div_zero, 0);
        for (int i = 0; i < 6; i++) exp_x[i] = '0;
        check_x("T6 cleared", exp_x);
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("T6 no done", ndone, 0);
        run_solve("T6 fresh", exp_t1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
